// File: rtl/uart_wb_arbiter_pkg.sv
// Shared constants and FSM encoding for the two-requester UART bus arbiter.
package uart_bus_pkg;

  localparam int UART_ADDR_W = 2;
  localparam int UART_DATA_W = 8;
  localparam logic [UART_DATA_W-1:0] ERR_DATA = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_wb_arbiter_if.sv
// Bundle of both requester ports plus the UART-facing bus port.
// slave = arbiter view, master = environment (requesters + UART) view.
interface uart_wb_arbiter_if;
  import uart_bus_pkg::*;

  logic [UART_ADDR_W-1:0] s0_addr;
  logic [UART_DATA_W-1:0] s0_data_in;
  logic                   s0_we;
  logic                   s0_stb;
  logic [UART_DATA_W-1:0] s0_data_out;
  logic                   s0_ack;
  logic                   s0_err;

  logic [UART_ADDR_W-1:0] s1_addr;
  logic [UART_DATA_W-1:0] s1_data_in;
  logic                   s1_we;
  logic                   s1_stb;
  logic [UART_DATA_W-1:0] s1_data_out;
  logic                   s1_ack;
  logic                   s1_err;

  logic [UART_ADDR_W-1:0] m_addr;
  logic [UART_DATA_W-1:0] m_data_out;
  logic                   m_we;
  logic                   m_stb;
  logic [UART_DATA_W-1:0] m_data_in;
  logic                   m_ack;

  modport slave (
    input  s0_addr, s0_data_in, s0_we, s0_stb,
    output s0_data_out, s0_ack, s0_err,
    input  s1_addr, s1_data_in, s1_we, s1_stb,
    output s1_data_out, s1_ack, s1_err,
    output m_addr, m_data_out, m_we, m_stb,
    input  m_data_in, m_ack
  );

  modport master (
    output s0_addr, s0_data_in, s0_we, s0_stb,
    input  s0_data_out, s0_ack, s0_err,
    output s1_addr, s1_data_in, s1_we, s1_stb,
    input  s1_data_out, s1_ack, s1_err,
    input  m_addr, m_data_out, m_we, m_stb,
    output m_data_in, m_ack
  );

endinterface

// File: rtl/uart_wb_arbiter_timeout_ctr.sv
// Saturating wait counter for one bus transaction; expired_o flags the last
// cycle before the arbiter must abort with an error-ack.
module wb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX  = {CW{1'b1}};

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_wb_arbiter.sv
// Round-robin arbiter sharing the UART register port between two requesters,
// holding each grant for one transaction and aborting stalled ones with err.
module uart_wb_arbiter
  import uart_bus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             reset,
  uart_wb_arbiter_if.slave bus
);

  arb_state_e state_q, state_d;
  logic gnt_q, gnt_d;
  logic last_q, last_d;

  logic [UART_ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [UART_DATA_W-1:0] m_data_q, m_data_d;
  logic                   m_we_q, m_we_d;
  logic                   m_stb_q, m_stb_d;

  logic [1:0][UART_DATA_W-1:0] s_data_q, s_data_d;
  logic [1:0]                  s_ack_q, s_ack_d;
  logic [1:0]                  s_err_q, s_err_d;

  logic [1:0]                  req_stb;
  logic [1:0]                  req_we;
  logic [1:0][UART_ADDR_W-1:0] req_addr;
  logic [1:0][UART_DATA_W-1:0] req_data;

  logic ctr_clr, ctr_inc, ctr_expired;

  assign req_stb  = {bus.s1_stb, bus.s0_stb};
  assign req_we   = {bus.s1_we, bus.s0_we};
  assign req_addr = {bus.s1_addr, bus.s0_addr};
  assign req_data = {bus.s1_data_in, bus.s0_data_in};

  wb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst_n    (reset),
    .clr_i    (ctr_clr),
    .inc_i    (ctr_inc),
    .expired_o(ctr_expired)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    m_addr_d = m_addr_q;
    m_data_d = m_data_q;
    m_we_d   = m_we_q;
    m_stb_d  = m_stb_q;
    s_data_d = s_data_q;
    s_ack_d  = '0;
    s_err_d  = '0;
    ctr_clr  = 1'b0;
    ctr_inc  = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_stb) begin
          // Contention goes to whoever did not win last time.
          gnt_d    = (&req_stb) ? ~last_q : req_stb[1];
          last_d   = gnt_d;
          m_addr_d = req_addr[gnt_d];
          m_data_d = req_data[gnt_d];
          m_we_d   = req_we[gnt_d];
          m_stb_d  = 1'b1;
          ctr_clr  = 1'b1;
          state_d  = BUS;
        end
      end
      BUS: begin
        // A real ack beats a simultaneous expiry.
        if (bus.m_ack) begin
          m_stb_d         = 1'b0;
          s_data_d[gnt_q] = bus.m_data_in;
          s_ack_d[gnt_q]  = 1'b1;
          state_d         = DONE;
        end else if (ctr_expired) begin
          m_stb_d         = 1'b0;
          s_data_d[gnt_q] = ERR_DATA;
          s_ack_d[gnt_q]  = 1'b1;
          s_err_d[gnt_q]  = 1'b1;
          state_d         = DONE;
        end else begin
          ctr_inc = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      m_addr_q <= '0;
      m_data_q <= '0;
      m_we_q   <= 1'b0;
      m_stb_q  <= 1'b0;
      s_data_q <= '0;
      s_ack_q  <= '0;
      s_err_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      m_addr_q <= m_addr_d;
      m_data_q <= m_data_d;
      m_we_q   <= m_we_d;
      m_stb_q  <= m_stb_d;
      s_data_q <= s_data_d;
      s_ack_q  <= s_ack_d;
      s_err_q  <= s_err_d;
    end
  end

  assign bus.m_addr      = m_addr_q;
  assign bus.m_data_out  = m_data_q;
  assign bus.m_we        = m_we_q;
  assign bus.m_stb       = m_stb_q;
  assign bus.s0_data_out = s_data_q[0];
  assign bus.s0_ack      = s_ack_q[0];
  assign bus.s0_err      = s_err_q[0];
  assign bus.s1_data_out = s_data_q[1];
  assign bus.s1_ack      = s_ack_q[1];
  assign bus.s1_err      = s_err_q[1];

endmodule
